nucleic_acid_valve_sequencer: RTL

Clocked controller that drives the pneumatic control lines of the 12-reactor nucleic-acid extraction array: every `*_ctl` line plus the three peristaltic pump lines. It is the producer side of the valve-control interface. It steps the shared reactor bank through the load, lysis, bead-capture, wash, elute and collect phases, with a break-before-make gap between phases and a 6-step peristaltic pump pattern. It sits between the host/test register block and the chip pin driver.

---
 rtl/nucleic_acid_ctl_pkg.sv | 87 ++++++++
 rtl/peristaltic_pump_driver.sv | 77 +++++++
 rtl/nucleic_acid_valve_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/nucleic_acid_ctl_pkg.sv
// Shared phase encoding, valve bit map, pump pattern and phase helpers
// for the nucleic-acid extraction valve sequencer.
package nucleic_acid_ctl_pkg;

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_GAP     = 3'd1,
      PH_LOAD    = 3'd2,
      PH_LYSIS   = 3'd3,
      PH_CAPTURE = 3'd4,
      PH_WASH    = 3'd5,
      PH_ELUTE   = 3'd6,
      PH_COLLECT = 3'd7
   } phase_e;

   localparam int unsigned NUM_VALVES   = 10;
   localparam int unsigned V_LYSIS      = 0;
   localparam int unsigned V_WASH       = 1;
   localparam int unsigned V_ELUTE      = 2;
   localparam int unsigned V_HORIZ      = 3;
   localparam int unsigned V_DEAD_END   = 4;
   localparam int unsigned V_LOOP_EXIT  = 5;
   localparam int unsigned V_BEAD_VTL   = 6;
   localparam int unsigned V_COLLECTION = 7;
   localparam int unsigned V_VERTICAL   = 8;
   localparam int unsigned V_BEAD_TRAP  = 9;

   typedef logic [NUM_VALVES-1:0] valve_vec_t;

   // Entry [0] is the first step of a stroke: {pump1,pump2,pump3}.
   localparam logic [5:0][2:0] PUMP_PATTERN = {
      3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100
   };

   function automatic valve_vec_t open_mask(phase_e ph);
      valve_vec_t m;
      m = '0;
      case (ph)
         PH_LOAD: begin
            m[V_HORIZ]    = 1'b1;
            m[V_DEAD_END] = 1'b1;
         end
         PH_LYSIS: begin
            m[V_LYSIS]    = 1'b1;
            m[V_VERTICAL] = 1'b1;
         end
         PH_CAPTURE: begin
            m[V_BEAD_VTL]  = 1'b1;
            m[V_BEAD_TRAP] = 1'b1;
            m[V_LOOP_EXIT] = 1'b1;
         end
         PH_WASH: begin
            m[V_WASH]      = 1'b1;
            m[V_VERTICAL]  = 1'b1;
            m[V_BEAD_TRAP] = 1'b1;
         end
         PH_ELUTE: begin
            m[V_ELUTE]    = 1'b1;
            m[V_VERTICAL] = 1'b1;
         end
         PH_COLLECT: begin
            m[V_COLLECTION] = 1'b1;
            m[V_BEAD_TRAP]  = 1'b1;
            m[V_LOOP_EXIT]  = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic logic is_pumping(phase_e ph);
      return (ph == PH_LYSIS) || (ph == PH_CAPTURE) ||
             (ph == PH_WASH)  || (ph == PH_ELUTE);
   endfunction

   // First phase after cur whose count is non-zero (act is indexed by phase
   // code); PH_IDLE means the run is complete.
   function automatic phase_e next_exec(phase_e cur, logic [7:0] act);
      phase_e nx;
      nx = PH_IDLE;
      for (int unsigned c = 7; c > 1; c--) begin
         if ((c > 32'(cur)) && act[c[2:0]]) nx = phase_e'(c[2:0]);
      end
      return nx;
   endfunction

endpackage

// File: rtl/peristaltic_pump_driver.sv
// Six-step peristaltic pump pattern generator; restarts at step 0 each time
// en rises and flags the final clock of the final stroke on last.
module peristaltic_pump_driver
   import nucleic_acid_ctl_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 4,
   parameter int unsigned SW          = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [SW-1:0] strokes,
   output logic [2:0]    pump,
   output logic          last
);

   localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    step_q, step_d;
   logic [SW-1:0] stroke_q, stroke_d;
   logic          active_q, active_d;
   logic [2:0]    pump_q, pump_d;
   logic          last_q, last_d;

   // Counters track the position shown on pump_q in the following cycle.
   always_comb begin
      tick_d   = '0;
      step_d   = '0;
      stroke_d = '0;
      active_d = 1'b0;
      if (en) begin
         active_d = 1'b1;
         if (active_q) begin
            tick_d   = tick_q;
            step_d   = step_q;
            stroke_d = stroke_q;
            if (tick_q == TW'(STEP_CYCLES - 1)) begin
               tick_d = '0;
               if (step_q == 3'd5) begin
                  step_d   = '0;
                  stroke_d = stroke_q + SW'(1);
               end else begin
                  step_d = step_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
      end
      pump_d = en ? PUMP_PATTERN[step_d] : 3'b000;
      last_d = en && (tick_d == TW'(STEP_CYCLES - 1)) && (step_d == 3'd5) &&
               (stroke_d == strokes - SW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q   <= '0;
         step_q   <= '0;
         stroke_q <= '0;
         active_q <= 1'b0;
         pump_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         step_q   <= step_d;
         stroke_q <= stroke_d;
         active_q <= active_d;
         pump_q   <= pump_d;
         last_q   <= last_d;
      end
   end

   assign pump = pump_q;
   assign last = last_q;

endmodule

// File: rtl/nucleic_acid_valve_sequencer.sv
// Phase sequencer for the 12-reactor extraction array: steps LOAD..COLLECT
// with break-before-make gaps and drives every valve and pump line.
module nucleic_acid_valve_sequencer
   import nucleic_acid_ctl_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 2,
   parameter int unsigned CW          = 16,
   parameter int unsigned SW          = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] load_cycles,
   input  logic [CW-1:0] collect_cycles,
   input  logic [SW-1:0] mix_strokes,
   input  logic [SW-1:0] cap_strokes,
   input  logic [SW-1:0] wash_strokes,
   input  logic [SW-1:0] elute_strokes,
   output logic          lysis_ctl,
   output logic          wash_ctl,
   output logic          elute_ctl,
   output logic          horiz_ctl,
   output logic          dead_end_ctl,
   output logic          loop_exit_ctl,
   output logic          bead_vtl_ctl,
   output logic          collection_ctl,
   output logic          vertical_ctl,
   output logic          bead_trap_ctl,
   output logic          pump1,
   output logic          pump2,
   output logic          pump3,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic [2:0]    phase
);

   phase_e        state_q, state_d;
   phase_e        after_q, after_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] load_q, load_d, collect_q, collect_d;
   logic [SW-1:0] mix_q, mix_d, cap_q, cap_d, wash_q, wash_d, elute_q, elute_d;
   valve_vec_t    valves_q, valves_d;
   logic          busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

   logic [7:0]    nz_in, nz_cfg;
   logic          phase_end;
   phase_e        nx;
   logic          pump_en, pump_last;
   logic [SW-1:0] pump_strokes;
   logic [2:0]    pump_w;

   assign nz_in  = {collect_cycles != '0, elute_strokes != '0, wash_strokes != '0,
                    cap_strokes != '0, mix_strokes != '0, load_cycles != '0, 2'b00};
   assign nz_cfg = {collect_q != '0, elute_q != '0, wash_q != '0,
                    cap_q != '0, mix_q != '0, load_q != '0, 2'b00};

   always_comb begin
      state_d   = state_q;
      after_d   = after_q;
      cnt_d     = cnt_q;
      load_d    = load_q;
      collect_d = collect_q;
      mix_d     = mix_q;
      cap_d     = cap_q;
      wash_d    = wash_q;
      elute_d   = elute_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      phase_end = 1'b0;
      nx        = PH_IDLE;

      case (state_q)
         PH_IDLE: begin
            if (start && !abort) begin
               load_d    = load_cycles;
               collect_d = collect_cycles;
               mix_d     = mix_strokes;
               cap_d     = cap_strokes;
               wash_d    = wash_strokes;
               elute_d   = elute_strokes;
               state_d   = PH_GAP;
               cnt_d     = '0;
               after_d   = next_exec(PH_IDLE, nz_in);
            end
         end
         PH_GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               cnt_d = '0;
               if (after_q == PH_IDLE) begin
                  state_d = PH_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = after_q;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PH_LOAD: begin
            if (cnt_q == load_q - CW'(1)) phase_end = 1'b1;
            else                          cnt_d = cnt_q + CW'(1);
         end
         PH_COLLECT: begin
            if (cnt_q == collect_q - CW'(1)) phase_end = 1'b1;
            else                             cnt_d = cnt_q + CW'(1);
         end
         default: begin
            if (pump_last) phase_end = 1'b1;
         end
      endcase

      if (phase_end) begin
         nx    = next_exec(state_q, nz_cfg);
         cnt_d = '0;
         if (nx == PH_IDLE) begin
            state_d = PH_IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = PH_GAP;
            after_d = nx;
         end
      end

      if (abort && (state_q != PH_IDLE)) begin
         state_d   = PH_IDLE;
         cnt_d     = '0;
         done_d    = 1'b0;
         aborted_d = 1'b1;
      end

      busy_d   = (state_d != PH_IDLE);
      valves_d = open_mask(state_d);
   end

   // Pump driver looks one cycle ahead so its registered pattern lines up
   // with the first cycle of each pumping phase.
   always_comb begin
      pump_en = is_pumping(state_d);
      case (state_d)
         PH_LYSIS:   pump_strokes = mix_q;
         PH_CAPTURE: pump_strokes = cap_q;
         PH_WASH:    pump_strokes = wash_q;
         PH_ELUTE:   pump_strokes = elute_q;
         default:    pump_strokes = '0;
      endcase
   end

   peristaltic_pump_driver #(
      .STEP_CYCLES (STEP_CYCLES),
      .SW          (SW)
   ) u_pump (
      .clk     (clk),
      .rst     (rst),
      .en      (pump_en),
      .strokes (pump_strokes),
      .pump    (pump_w),
      .last    (pump_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= PH_IDLE;
         after_q   <= PH_IDLE;
         cnt_q     <= '0;
         load_q    <= '0;
         collect_q <= '0;
         mix_q     <= '0;
         cap_q     <= '0;
         wash_q    <= '0;
         elute_q   <= '0;
         valves_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         after_q   <= after_d;
         cnt_q     <= cnt_d;
         load_q    <= load_d;
         collect_q <= collect_d;
         mix_q     <= mix_d;
         cap_q     <= cap_d;
         wash_q    <= wash_d;
         elute_q   <= elute_d;
         valves_q  <= valves_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign lysis_ctl      = valves_q[V_LYSIS];
   assign wash_ctl       = valves_q[V_WASH];
   assign elute_ctl      = valves_q[V_ELUTE];
   assign horiz_ctl      = valves_q[V_HORIZ];
   assign dead_end_ctl   = valves_q[V_DEAD_END];
   assign loop_exit_ctl  = valves_q[V_LOOP_EXIT];
   assign bead_vtl_ctl   = valves_q[V_BEAD_VTL];
   assign collection_ctl = valves_q[V_COLLECTION];
   assign vertical_ctl   = valves_q[V_VERTICAL];
   assign bead_trap_ctl  = valves_q[V_BEAD_TRAP];
   assign pump1          = pump_w[2];
   assign pump2          = pump_w[1];
   assign pump3          = pump_w[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign phase          = state_q;

endmodule
